// File: rtl/piton_l15_responder_if.sv
// Core <-> L1.5 request/response bundle used by piton_l15_responder.
// master = core-side memory wrapper, slave = the responder.
interface piton_l15_responder_if;
  logic [5:0]  core_l15_rqtype;
  logic [2:0]  core_l15_size;
  logic [31:0] core_l15_address;
  logic [31:0] core_l15_data;
  logic        core_l15_val;
  logic        l15_core_ack;
  logic        l15_core_header_ack;
  logic        l15_core_val;
  logic [3:0]  l15_core_returntype;
  logic [63:0] l15_core_data_0;
  logic [63:0] l15_core_data_1;
  logic        core_l15_req_ack;

  modport master (
    output core_l15_rqtype, core_l15_size, core_l15_address, core_l15_data,
           core_l15_val, core_l15_req_ack,
    input  l15_core_ack, l15_core_header_ack, l15_core_val, l15_core_returntype,
           l15_core_data_0, l15_core_data_1
  );

  modport slave (
    input  core_l15_rqtype, core_l15_size, core_l15_address, core_l15_data,
           core_l15_val, core_l15_req_ack,
    output l15_core_ack, l15_core_header_ack, l15_core_val, l15_core_returntype,
           l15_core_data_0, l15_core_data_1
  );
endinterface

// File: rtl/piton_l15_responder.sv
// Simulation-grade L1.5 responder: services core loads/stores from a word memory.
// Optional macro L15_RESP_STALL_EN adds LFSR-driven ack stalls and extra latency.
module piton_l15_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                        clk,
  input  logic                        nrst,
  piton_l15_responder_if.slave        bus,
  output logic                        err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [3:0] LOAD_RET = 4'd0;
  localparam logic [3:0] ST_ACK   = 4'd4;
  localparam logic [5:0] RQ_LOAD  = 6'd0;
  localparam logic [5:0] RQ_STORE = 6'd1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [8:0]    cnt, cnt_nxt;
  logic [8:0]    wait_total;
  logic [8:0]    extra;
  logic          stall;
  logic          accept;
  logic          enter_resp;

  logic [AW-1:0] req_idx;
  logic          req_load;
  logic [3:0]    rt_q;
  logic [63:0]   data0_q, data1_q;

  logic [31:0]   mem [DEPTH_WORDS];

  // Request decode on the live bus (only meaningful on the acceptance edge).
  logic [AW-1:0] in_idx;
  logic [1:0]    in_off;
  logic          in_load, in_store, in_illegal;
  logic          misaligned, proto_err, wr_en;
  logic [3:0]    wr_mask;
  logic [31:0]   wr_data;
  logic          unused_addr_bits;

  assign in_idx           = bus.core_l15_address[AW+1:2];
  assign in_off           = bus.core_l15_address[1:0];
  assign unused_addr_bits = ^bus.core_l15_address[31:AW+2];
  assign in_load          = (bus.core_l15_rqtype == RQ_LOAD);
  assign in_store         = (bus.core_l15_rqtype == RQ_STORE);
  assign in_illegal       = !in_load && !in_store;

  // Byte lanes are big-endian: wr_mask[3] is offset 0 (bits 31:24).
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_mask    = 4'b0000;
    wr_data    = 32'h0;
    misaligned = 1'b0;
    case (bus.core_l15_size)
      3'd1: begin
        wr_mask = 4'b1000 >> in_off;
        wr_data = {4{bus.core_l15_data[31:24]}};
      end
      3'd2: begin
        misaligned = in_off[0];
        wr_mask    = in_off[1] ? 4'b0011 : 4'b1100;
        wr_data    = {2{bus.core_l15_data[31:16]}};
      end
      3'd3: begin
        misaligned = |in_off;
        wr_mask    = 4'b1111;
        wr_data    = bus.core_l15_data;
      end
      default: ;
    endcase
  end

  assign proto_err = in_illegal || (in_store && misaligned);
  assign wr_en     = accept && in_store && !misaligned && (|wr_mask);

`ifdef L15_RESP_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR for x^16 + x^14 + x^13 + x^11.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = lfsr[0];
  assign extra = {7'd0, lfsr[2:1]};
`else
  assign stall = 1'b0;
  assign extra = 9'd0;
`endif

  assign wait_total = 9'(LATENCY) + extra;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.core_l15_val && !stall;
        if (accept) begin
          if (wait_total == 9'd0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = wait_total;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 9'd1;
        if (cnt <= 9'd1) state_nxt = RESP;
      end
      RESP: begin
        if (bus.core_l15_req_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == RESP) && (state != RESP);

  // With zero latency the response is built on the acceptance edge itself,
  // so the live request is used instead of the latched one.
  logic          cur_load;
  logic [AW-1:0] cur_idx;
  logic [AW-1:0] base0, base1, base2, base3;

  assign cur_load = (state == IDLE) ? in_load : req_load;
  assign cur_idx  = (state == IDLE) ? in_idx  : req_idx;
  assign base0    = {cur_idx[AW-1:2], 2'b00};
  assign base1    = {cur_idx[AW-1:2], 2'b01};
  assign base2    = {cur_idx[AW-1:2], 2'b10};
  assign base3    = {cur_idx[AW-1:2], 2'b11};

  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!nrst) begin
      state    <= IDLE;
      cnt      <= 9'd0;
      req_idx  <= '0;
      req_load <= 1'b0;
      rt_q     <= LOAD_RET;
      data0_q  <= 64'h0;
      data1_q  <= 64'h0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        req_idx  <= in_idx;
        req_load <= in_load;
        if (proto_err) err <= 1'b1;
      end
      if (enter_resp) begin
        rt_q <= cur_load ? LOAD_RET : ST_ACK;
        if (cur_load) begin
          data0_q <= {mem[base0], mem[base1]};
          data1_q <= {mem[base2], mem[base3]};
        end
      end
    end
  end

  // NOTE: the backing store has no reset; clearing a RAM costs a port-wide loop and contents must survive nrst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem[in_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign bus.l15_core_ack        = accept;
  assign bus.l15_core_header_ack = accept;
  assign bus.l15_core_val        = (state == RESP);
  assign bus.l15_core_returntype = rt_q;
  assign bus.l15_core_data_0     = data0_q;
  assign bus.l15_core_data_1     = data1_q;
endmodule

// File: tb/tb_piton_l15_responder.sv
// Self-checking bench for piton_l15_responder: directed table, corner sequences,
// and randomized traffic checked against a byte-level memory model.
module tb_piton_l15_responder;
  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  piton_l15_responder_if bus1 ();
  piton_l15_responder_if bus0 ();
  logic err1, err0;

  // Shared stimulus; sel picks which DUT sees val/req_ack (0 = LATENCY 2, 1 = LATENCY 0).
  logic        sel    = 1'b0;
  logic [5:0]  rq_s   = '0;
  logic [2:0]  sz_s   = '0;
  logic [31:0] addr_s = '0;
  logic [31:0] data_s = '0;
  logic        val_s  = 1'b0;
  logic        rack_s = 1'b0;

  assign bus1.core_l15_rqtype  = rq_s;
  assign bus1.core_l15_size    = sz_s;
  assign bus1.core_l15_address = addr_s;
  assign bus1.core_l15_data    = data_s;
  assign bus1.core_l15_val     = val_s & ~sel;
  assign bus1.core_l15_req_ack = rack_s & ~sel;
  assign bus0.core_l15_rqtype  = rq_s;
  assign bus0.core_l15_size    = sz_s;
  assign bus0.core_l15_address = addr_s;
  assign bus0.core_l15_data    = data_s;
  assign bus0.core_l15_val     = val_s & sel;
  assign bus0.core_l15_req_ack = rack_s & sel;

  logic        m_ack, m_hack, m_val, m_err;
  logic [3:0]  m_rt;
  logic [63:0] m_d0, m_d1;
  assign m_ack  = sel ? bus0.l15_core_ack        : bus1.l15_core_ack;
  assign m_hack = sel ? bus0.l15_core_header_ack : bus1.l15_core_header_ack;
  assign m_val  = sel ? bus0.l15_core_val        : bus1.l15_core_val;
  assign m_rt   = sel ? bus0.l15_core_returntype : bus1.l15_core_returntype;
  assign m_d0   = sel ? bus0.l15_core_data_0     : bus1.l15_core_data_0;
  assign m_d1   = sel ? bus0.l15_core_data_1     : bus1.l15_core_data_1;
  assign m_err  = sel ? err0 : err1;

  piton_l15_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut1 (
    .clk(clk), .nrst(nrst), .bus(bus1.slave), .err(err1));
  piton_l15_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
    .clk(clk), .nrst(nrst), .bus(bus0.slave), .err(err0));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural model: 1024 words addressed by byte lanes, lane 0 = most significant byte.
  logic [31:0] mm [1024];
  bit          model_err = 1'b0;

  function automatic void model_req(input logic [5:0] rq, input logic [2:0] sz,
                                    input logic [31:0] a, input logic [31:0] d,
                                    output logic [3:0] rt, output logic [63:0] d0,
                                    output logic [63:0] d1);
    int idx, base, nb, off, lane;
    idx  = int'(a[11:2]);
    base = idx - (idx % 4);
    off  = int'(a[1:0]);
    d0   = '0;
    d1   = '0;
    if (rq == 6'd0) begin
      rt = 4'd0;
      d0 = {mm[base], mm[base+1]};
      d1 = {mm[base+2], mm[base+3]};
    end else begin
      rt = 4'd4;
      if (rq != 6'd1) begin
        model_err = 1'b1;
      end else begin
        nb = (sz == 3'd3) ? 4 : (sz == 3'd2) ? 2 : (sz == 3'd1) ? 1 : 0;
        if (nb > 0 && (off % nb) != 0) begin
          model_err = 1'b1;
        end else begin
          for (int k = 0; k < nb; k++) begin
            lane = off + k;
            mm[idx][31-8*lane -: 8] = d[31-8*k -: 8];
          end
        end
      end
    end
  endfunction

  // One full request/response; checks latency, stability while held and release.
  task automatic transact(input logic [5:0] rq, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input int hold, input bit keep_val,
                          output logic [3:0] rt, output logic [63:0] d0, output logic [63:0] d1);
    int n, extra_acks;
    bit got;
    rt = '0; d0 = '0; d1 = '0;
    @(negedge clk);
    rq_s = rq; sz_s = sz; addr_s = a; data_s = d; val_s = 1'b1; rack_s = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (m_ack) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      check("accept_timeout", 64'(0), 64'(1));
      val_s = 1'b0;
      return;
    end
    check("header_ack", 64'(m_hack), 64'(1));
    @(posedge clk);
    @(negedge clk);
    if (!keep_val) val_s = 1'b0;
    #1;
    n = 1;
    extra_acks = 0;
    while (!m_val && n < 300) begin
      if (m_ack) extra_acks++;
      @(negedge clk); #1;
      n++;
    end
    if (!m_val) begin
      check("resp_timeout", 64'(0), 64'(1));
      val_s = 1'b0;
      return;
    end
    check("latency", 64'(n), sel ? 64'(1) : 64'(3));
    rt = m_rt; d0 = m_d0; d1 = m_d1;
    for (int h = 0; h < hold; h++) begin
      if (m_ack) extra_acks++;
      @(negedge clk); #1;
      check("hold_val", 64'(m_val), 64'(1));
      check("hold_rt", 64'(m_rt), 64'(rt));
      check("hold_d0", m_d0, d0);
      check("hold_d1", m_d1, d1);
    end
    if (m_ack) extra_acks++;
    rack_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rack_s = 1'b0;
    #1;
    check("resp_release", 64'(m_val), 64'(0));
    if (keep_val) begin
      check("single_ack", 64'(extra_acks), 64'(0));
      check("reaccept", 64'(m_ack), 64'(1));
      val_s = 1'b0;
    end
  endtask

  // Request on the LATENCY=2 DUT checked against the model.
  task automatic run_model(input string tag, input logic [5:0] rq, input logic [2:0] sz,
                           input logic [31:0] a, input logic [31:0] d, input int hold,
                           input bit keep_val);
    logic [3:0]  ert, art;
    logic [63:0] ed0, ed1, ad0, ad1;
    model_req(rq, sz, a, d, ert, ed0, ed1);
    transact(rq, sz, a, d, hold, keep_val, art, ad0, ad1);
    check({tag, "_rt"}, 64'(art), 64'(ert));
    check({tag, "_err"}, 64'(m_err), 64'(model_err));
    if (rq == 6'd0) begin
      check({tag, "_d0"}, ad0, ed0);
      check({tag, "_d1"}, ad1, ed1);
    end
  endtask

  typedef struct {
    logic [5:0]  rq;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  rt;
    bit          is_load;
    logic [63:0] d0;
    logic [63:0] d1;
    bit          err;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rt, drt;
    logic [63:0] d0, d1, dd0, dd1;
    logic [5:0]  rrq;
    logic [2:0]  rsz;
    logic [31:0] ra;
    int          r;

    // Preload gives word i = 0xA5000000 | i for i in 0..63.
    tbl[0]  = '{6'd1, 3'd3, 32'h40,   32'hDEADBEEF, 4'd4, 1'b0, 64'h0, 64'h0, 1'b0};
    tbl[1]  = '{6'd0, 3'd3, 32'h44,   32'h0,        4'd0, 1'b1, 64'hDEADBEEF_A5000011, 64'hA5000012_A5000013, 1'b0};
    tbl[2]  = '{6'd1, 3'd1, 32'h80,   32'h11000000, 4'd4, 1'b0, 64'h0, 64'h0, 1'b0};
    tbl[3]  = '{6'd1, 3'd1, 32'h81,   32'h22000000, 4'd4, 1'b0, 64'h0, 64'h0, 1'b0};
    tbl[4]  = '{6'd1, 3'd1, 32'h82,   32'h33000000, 4'd4, 1'b0, 64'h0, 64'h0, 1'b0};
    tbl[5]  = '{6'd1, 3'd1, 32'h83,   32'h44000000, 4'd4, 1'b0, 64'h0, 64'h0, 1'b0};
    tbl[6]  = '{6'd0, 3'd3, 32'h80,   32'h0,        4'd0, 1'b1, 64'h11223344_A5000021, 64'hA5000022_A5000023, 1'b0};
    tbl[7]  = '{6'd1, 3'd2, 32'h82,   32'hAABB0000, 4'd4, 1'b0, 64'h0, 64'h0, 1'b0};
    tbl[8]  = '{6'd0, 3'd3, 32'h83,   32'h0,        4'd0, 1'b1, 64'h1122AABB_A5000021, 64'hA5000022_A5000023, 1'b0};
    tbl[9]  = '{6'd1, 3'd0, 32'h84,   32'hFFFFFFFF, 4'd4, 1'b0, 64'h0, 64'h0, 1'b0};
    tbl[10] = '{6'd0, 3'd3, 32'h88,   32'h0,        4'd0, 1'b1, 64'h1122AABB_A5000021, 64'hA5000022_A5000023, 1'b0};
    tbl[11] = '{6'd1, 3'd2, 32'h80,   32'hCCDD1234, 4'd4, 1'b0, 64'h0, 64'h0, 1'b0};
    tbl[12] = '{6'd0, 3'd3, 32'h8C,   32'h0,        4'd0, 1'b1, 64'hCCDDAABB_A5000021, 64'hA5000022_A5000023, 1'b0};
    tbl[13] = '{6'd1, 3'd2, 32'h41,   32'h12345678, 4'd4, 1'b0, 64'h0, 64'h0, 1'b1};
    tbl[14] = '{6'd1, 3'd3, 32'h42,   32'h12345678, 4'd4, 1'b0, 64'h0, 64'h0, 1'b1};
    tbl[15] = '{6'd5, 3'd3, 32'h40,   32'h12345678, 4'd4, 1'b0, 64'h0, 64'h0, 1'b1};
    tbl[16] = '{6'd0, 3'd3, 32'h40,   32'h0,        4'd0, 1'b1, 64'hDEADBEEF_A5000011, 64'hA5000012_A5000013, 1'b1};
    tbl[17] = '{6'd0, 3'd3, 32'h1040, 32'h0,        4'd0, 1'b1, 64'hDEADBEEF_A5000011, 64'hA5000012_A5000013, 1'b1};

    // Reset values on both instances.
    repeat (2) @(negedge clk);
    #1;
    check("rst_val1", 64'(bus1.l15_core_val), 64'(0));
    check("rst_ack1", 64'(bus1.l15_core_ack), 64'(0));
    check("rst_rt1",  64'(bus1.l15_core_returntype), 64'(0));
    check("rst_d0_1", bus1.l15_core_data_0, 64'h0);
    check("rst_d1_1", bus1.l15_core_data_1, 64'h0);
    check("rst_err1", 64'(err1), 64'(0));
    check("rst_val0", 64'(bus0.l15_core_val), 64'(0));
    check("rst_err0", 64'(err0), 64'(0));
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 64; i++) begin
      model_req(6'd1, 3'd3, 32'(i * 4), 32'hA5000000 | 32'(i), drt, dd0, dd1);
      transact(6'd1, 3'd3, 32'(i * 4), 32'hA5000000 | 32'(i), 0, 1'b0, rt, d0, d1);
    end

    for (int i = 0; i < 18; i++) begin
      model_req(tbl[i].rq, tbl[i].sz, tbl[i].addr, tbl[i].data, drt, dd0, dd1);
      transact(tbl[i].rq, tbl[i].sz, tbl[i].addr, tbl[i].data, i % 3, 1'b0, rt, d0, d1);
      check($sformatf("tbl%0d_rt", i), 64'(rt), 64'(tbl[i].rt));
      check($sformatf("tbl%0d_err", i), 64'(m_err), 64'(tbl[i].err));
      if (tbl[i].is_load) begin
        check($sformatf("tbl%0d_d0", i), d0, tbl[i].d0);
        check($sformatf("tbl%0d_d1", i), d1, tbl[i].d1);
      end
    end

    // val held high through a whole transaction, then a held 5-cycle response.
    run_model("keep_val", 6'd0, 3'd3, 32'h40, 32'h0, 2, 1'b1);
    run_model("hold5", 6'd0, 3'd3, 32'h80, 32'h0, 5, 1'b0);

    // Reset pulsed during WAIT of a store: response dropped, store kept, err cleared.
    @(negedge clk);
    rq_s = 6'd1; sz_s = 3'd3; addr_s = 32'hC0; data_s = 32'h5A5A1234; val_s = 1'b1;
    #1;
    check("rst_seq_ack", 64'(m_ack), 64'(1));
    model_req(6'd1, 3'd3, 32'hC0, 32'h5A5A1234, drt, dd0, dd1);
    @(posedge clk);
    @(negedge clk);
    val_s = 1'b0;
    nrst  = 1'b0;
    #1;
    check("midrst_val", 64'(m_val), 64'(0));
    check("midrst_ack", 64'(m_ack), 64'(0));
    check("midrst_rt",  64'(m_rt), 64'(0));
    check("midrst_d0",  m_d0, 64'h0);
    check("midrst_d1",  m_d1, 64'h0);
    check("midrst_err", 64'(m_err), 64'(0));
    model_err = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("midrst_no_resp", 64'(m_val), 64'(0));
    end
    run_model("after_rst", 6'd0, 3'd3, 32'hC4, 32'h0, 0, 1'b0);

    // Randomized traffic over the preloaded region, with address aliasing.
    for (int i = 0; i < 150; i++) begin
      r  = $urandom_range(0, 9);
      ra = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) ra = ra | ($urandom & 32'hFFFF_F000);
      rsz = 3'($urandom_range(0, 3));
      if (r < 5)      rrq = 6'd0;
      else if (r < 9) rrq = 6'd1;
      else            rrq = 6'($urandom_range(2, 63));
      run_model($sformatf("rnd%0d", i), rrq, rsz, ra, $urandom, $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    end

    // LATENCY = 0 instance: 0x1000 aliases to word 0, response in the next cycle.
    sel = 1'b1;
    transact(6'd1, 3'd3, 32'h1000, 32'hCAFEF00D, 0, 1'b0, rt, d0, d1);
    check("lat0_st_rt", 64'(rt), 64'(4));
    transact(6'd0, 3'd3, 32'h0000, 32'h0, 1, 1'b0, rt, d0, d1);
    check("lat0_ld_rt", 64'(rt), 64'(0));
    check("lat0_ld_w0", 64'(d0[63:32]), 64'h0000_0000_CAFEF00D);
    check("lat0_err", 64'(m_err), 64'(0));
    sel = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
